// File: rtl/keccak_lane_port.sv
// keccak_lane_port: lane-stream absorb/pad/squeeze endpoint for an external Keccak-f[1600] core.
// Ports: din/din_valid/buffer_full/last_block in, dout/dout_valid/ready out, perm_start/rate_out/perm_done/rate_in to core.
module keccak_lane_port #(
   parameter int RATE_LANES = 21,
   parameter int OUT_LANES  = 21
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [63:0]               din,
   input  logic                      din_valid,
   output logic                      buffer_full,
   input  logic                      last_block,
   output logic                      ready,
   output logic [63:0]               dout,
   output logic                      dout_valid,
   output logic                      perm_start,
   output logic [64*RATE_LANES-1:0]  rate_out,
   input  logic                      perm_done,
   input  logic [64*RATE_LANES-1:0]  rate_in
);

   localparam int CW = $clog2(RATE_LANES + 1);
   localparam int IW = $clog2(OUT_LANES + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(RATE_LANES);
   localparam logic [CW-1:0] CNT_LAST = CW'(RATE_LANES - 1);
   localparam logic [IW-1:0] IDX_END  = IW'(OUT_LANES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ABSORB,
      S_PERM,
      S_PAD,
      S_FINAL,
      S_SQUEEZE,
      S_DONE
   } state_e;

   state_e                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [RATE_LANES-1:0][63:0]    lane_q, lane_d;
   logic [OUT_LANES-1:0][63:0]     obuf_q, obuf_d;
   logic [63:0]                    dout_q, dout_d;
   logic                           dout_valid_q, dout_valid_d;
   logic                           ready_q, ready_d;
   logic                           perm_start_q, perm_start_d;
   logic [RATE_LANES-1:0][63:0]    rin;

   assign rin = rate_in;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      lane_d       = lane_q;
      obuf_d       = obuf_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      ready_d      = ready_q;
      perm_start_d = 1'b0;
      if (start) begin
         state_d      = S_IDLE;
         cnt_d        = '0;
         idx_d        = '0;
         lane_d       = '0;
         dout_valid_d = 1'b0;
         ready_d      = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_ABSORB;
            S_ABSORB: begin
               if (cnt_q == CNT_FULL) begin
                  perm_start_d = 1'b1;
                  state_d      = S_PERM;
               end else if (din_valid) begin
                  lane_d[cnt_q] = din;
                  cnt_d         = cnt_q + 1'b1;
                  // launch on the accepting edge so the pulse follows the last lane
                  if (cnt_q == CNT_LAST) begin
                     perm_start_d = 1'b1;
                     state_d      = S_PERM;
                  end
               end else if (last_block) begin
                  state_d = S_PAD;
               end
            end
            S_PERM: begin
               if (perm_done) begin
                  cnt_d   = '0;
                  state_d = S_ABSORB;
               end
            end
            S_PAD: begin
               for (int i = 0; i < RATE_LANES; i++) begin
                  if (i > int'(cnt_q)) begin
                     lane_d[i] = '0;
                  end else if (i == int'(cnt_q)) begin
                     lane_d[i] = 64'h1F;
                  end
               end
               lane_d[RATE_LANES-1] = lane_d[RATE_LANES-1] | 64'h8000_0000_0000_0000;
               perm_start_d = 1'b1;
               state_d      = S_FINAL;
            end
            S_FINAL: begin
               if (perm_done) begin
                  for (int i = 0; i < OUT_LANES; i++) begin
                     obuf_d[i] = rin[i];
                  end
                  // lane 0 goes out directly with the latch
                  dout_d       = rin[0];
                  dout_valid_d = 1'b1;
                  ready_d      = 1'b1;
                  idx_d        = IW'(1);
                  state_d      = S_SQUEEZE;
               end
            end
            S_SQUEEZE: begin
               if (idx_q == IDX_END) begin
                  dout_valid_d = 1'b0;
                  state_d      = S_DONE;
               end else begin
                  dout_d = obuf_q[idx_q];
                  idx_d  = idx_q + 1'b1;
               end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         lane_q       <= '0;
         obuf_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         ready_q      <= 1'b0;
         perm_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         lane_q       <= lane_d;
         obuf_q       <= obuf_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         ready_q      <= ready_d;
         perm_start_q <= perm_start_d;
      end
   end

   assign buffer_full = (state_q != S_ABSORB) || (cnt_q == CNT_FULL);
   assign ready       = ready_q;
   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign perm_start  = perm_start_q;
   assign rate_out    = lane_q;

endmodule

// File: tb/tb_keccak_lane_port.sv
// tb_keccak_lane_port: directed bench with a message-to-block model and a responding permutation core.
// Checks padded blocks on every perm_start, digest lanes on every dout_valid, plus literal pins.
module tb_keccak_lane_port;

   localparam int RL = 21;
   localparam int OL = 21;
   localparam int W  = RL * 64;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [63:0]   din;
   logic          din_valid;
   logic          buffer_full;
   logic          last_block;
   logic          ready;
   logic [63:0]   dout;
   logic          dout_valid;
   logic          perm_start;
   logic [W-1:0]  rate_out;
   logic          perm_done;
   logic [W-1:0]  rate_in;

   int tests = 0;
   int fails = 0;

   logic [63:0]  msg[$];
   logic [W-1:0] exp_blk_q[$];
   logic [63:0]  exp_dout_q[$];
   logic [63:0]  got_dout[$];
   logic [W-1:0] last_ps_rate;

   int perm_lat  = 4;
   int rin_tag   = 0;
   int task_no   = 0;
   int msg_resp  = 0;
   int ps_cnt    = 0;
   int dv_cnt    = 0;
   bit resp_busy = 0;

   keccak_lane_port #(
      .RATE_LANES(RL),
      .OUT_LANES (OL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .buffer_full(buffer_full),
      .last_block (last_block),
      .ready      (ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .perm_start (perm_start),
      .rate_out   (rate_out),
      .perm_done  (perm_done),
      .rate_in    (rate_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic flag(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: event not expected here", nm);
   endtask

   // compare process: every perm_start and every dout_valid cycle
   initial begin
      logic [W-1:0] e;
      int fl;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (perm_start) begin
               ps_cnt++;
               last_ps_rate = rate_out;
               if (exp_blk_q.size() == 0) begin
                  flag("perm_start_unexpected");
               end else begin
                  e = exp_blk_q.pop_front();
                  tests++;
                  if (rate_out !== e) begin
                     fails++;
                     fl = 0;
                     for (int i = 0; i < RL; i++) begin
                        if (rate_out[64*i +: 64] !== e[64*i +: 64]) begin
                           fl = i;
                           break;
                        end
                     end
                     $display("FAIL rate_out lane %0d: got %h expected %h",
                              fl, rate_out[64*fl +: 64], e[64*fl +: 64]);
                  end
               end
            end
            if (dout_valid) begin
               dv_cnt++;
               got_dout.push_back(dout);
               chk("ready_with_dout", 64'(ready), 64'd1);
               if (exp_dout_q.size() == 0) flag("dout_unexpected");
               else chk("dout", dout, exp_dout_q.pop_front());
            end
         end
      end
   end

   // permutation core stand-in
   initial begin
      logic [W-1:0] snap;
      bit stable;
      bit start_seen;
      perm_done = 1'b0;
      rate_in   = '0;
      forever begin
         @(negedge clk);
         if (rst_n && perm_start) begin
            resp_busy  = 1;
            snap       = rate_out;
            stable     = 1;
            start_seen = 0;
            for (int k = 0; k < perm_lat; k++) begin
               @(negedge clk);
               if (start) start_seen = 1;
               if (rate_out !== snap) stable = 0;
            end
            @(posedge clk);
            #1;
            perm_done = 1'b1;
            for (int i = 0; i < RL; i++)
               rate_in[64*i +: 64] = {16'(rin_tag), 16'(msg_resp), 32'(i)};
            msg_resp++;
            @(posedge clk);
            #1;
            perm_done = 1'b0;
            if (!start_seen) chk("rate_out_stable", 64'(stable), 64'd1);
            resp_busy = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_msg(input int lat, input bit last_with, input bit lat_chk,
                          input bit restart, input bit abort, input int exp_perms);
      int n, nfull, r, ptr, to;
      bit acc;
      logic [W-1:0] blk;
      n     = msg.size();
      nfull = n / RL;
      r     = n % RL;
      to = 0;
      while (resp_busy && to < 300) begin
         @(posedge clk);
         to++;
      end
      chk("resp_idle", 64'(resp_busy), 64'd0);
      rin_tag  = task_no;
      task_no++;
      perm_lat = lat;
      msg_resp = 0;
      ps_cnt   = 0;
      dv_cnt   = 0;
      got_dout.delete();
      for (int b = 0; b < nfull; b++) begin
         blk = '0;
         for (int i = 0; i < RL; i++) blk[64*i +: 64] = msg[b*RL + i];
         exp_blk_q.push_back(blk);
      end
      blk = '0;
      for (int i = 0; i < r; i++) blk[64*i +: 64] = msg[nfull*RL + i];
      blk[64*r +: 64] = 64'h1F;
      blk[64*(RL-1) +: 64] = blk[64*(RL-1) +: 64] | 64'h8000_0000_0000_0000;
      exp_blk_q.push_back(blk);
      for (int i = 0; i < OL; i++)
         exp_dout_q.push_back({16'(rin_tag), 16'(nfull), 32'(i)});

      @(posedge clk);
      #1;
      start      = 1'b0;
      ptr        = 0;
      din        = msg[0];
      din_valid  = 1'b1;
      last_block = last_with && (n == 1);
      to = 0;
      while (ptr < n && to < 20*n + 200) begin
         @(negedge clk);
         acc = !buffer_full;
         @(posedge clk);
         #1;
         to++;
         if (acc) begin
            ptr++;
            if (ptr % RL == 0) begin
               chk("full_after_block", 64'(buffer_full), 64'd1);
               chk("perm_start_after_block", 64'(perm_start), 64'd1);
               if (restart) begin
                  din_valid = 1'b0;
                  din       = '0;
                  @(posedge clk);
                  #1;
                  start = 1'b1;
                  @(posedge clk);
                  #1;
                  chk("restart_idle_full", 64'(buffer_full), 64'd1);
                  chk("restart_cleared", 64'(|rate_out), 64'd0);
                  start = 1'b0;
                  @(posedge clk);
                  #1;
                  chk("restart_absorb", 64'(buffer_full), 64'd0);
                  chk("stale_pending", 64'(resp_busy), 64'd1);
                  return;
               end
            end
         end
         if (ptr < n) din = msg[ptr];
         else din = '0;
         din_valid  = (ptr < n);
         last_block = (ptr == n) || (last_with && ptr == n - 1);
      end
      chk("lanes_sent", 64'(ptr), 64'(n));
      if (lat_chk) begin
         @(posedge clk);
         #1;
         chk("pad_no_ps_yet", 64'(perm_start), 64'd0);
         @(posedge clk);
         #1;
         chk("pad_ps", 64'(perm_start), 64'd1);
      end
      to = 0;
      while (!ready && to < 500) begin
         @(posedge clk);
         #1;
         to++;
      end
      chk("ready_rise", 64'(ready), 64'd1);
      chk("dv_with_ready", 64'(dout_valid), 64'd1);
      if (abort) begin
         repeat (3) @(posedge clk);
         #1;
         return;
      end
      to = 0;
      while (dout_valid && to < 100) begin
         @(posedge clk);
         #1;
         to++;
      end
      chk("dout_valid_cycles", 64'(dv_cnt), 64'(OL));
      chk("perm_count", 64'(ps_cnt), 64'(exp_perms));
      chk("blocks_left", 64'(exp_blk_q.size()), 64'd0);
      chk("douts_left", 64'(exp_dout_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("ready_held", 64'(ready), 64'd1);
      chk("done_no_dv", 64'(dout_valid), 64'd0);
      last_block = 1'b0;
      start      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      last_block = 1'b0;
      #12;
      chk("rst_buffer_full", 64'(buffer_full), 64'd1);
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_dout_valid", 64'(dout_valid), 64'd0);
      chk("rst_perm_start", 64'(perm_start), 64'd0);
      chk("rst_dout", dout, 64'd0);
      chk("rst_rate_out", 64'(|rate_out), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_held_full", 64'(buffer_full), 64'd1);

      // single partial block
      msg.delete();
      msg.push_back(64'h1111_1111_1111_1111);
      msg.push_back(64'h2222_2222_2222_2222);
      msg.push_back(64'h3333_3333_3333_3333);
      run_msg(5, 0, 1, 0, 0, 1);
      chk("t1_lane0", last_ps_rate[63:0], 64'h1111_1111_1111_1111);
      chk("t1_lane3", last_ps_rate[255:192], 64'h1F);
      chk("t1_lane4", last_ps_rate[319:256], 64'h0);
      chk("t1_lane19", last_ps_rate[1279:1216], 64'h0);
      chk("t1_lane20", last_ps_rate[1343:1280], 64'h8000_0000_0000_0000);
      for (int i = 0; i < OL; i++) chk("t1_dout_lit", got_dout[i], 64'(i));

      // exact block boundary
      msg.delete();
      for (int k = 0; k < 21; k++) msg.push_back(64'hB0B0_0000_0000_0000 | 64'(k));
      run_msg(6, 0, 0, 0, 0, 2);
      chk("t2_lane0", last_ps_rate[63:0], 64'h1F);
      chk("t2_lane1", last_ps_rate[127:64], 64'h0);
      chk("t2_lane20", last_ps_rate[1343:1280], 64'h8000_0000_0000_0000);

      // lane 20 padding, last_block together with the last lane
      msg.delete();
      for (int k = 0; k < 20; k++) msg.push_back(64'hC0C0_0000_0000_0000 | 64'(k));
      run_msg(4, 1, 0, 0, 0, 1);
      chk("t3_lane19", last_ps_rate[1279:1216], 64'hC0C0_0000_0000_0013);
      chk("t3_lane20", last_ps_rate[1343:1280], 64'h8000_0000_0000_001F);

      // back-pressure through long permutations
      msg.delete();
      for (int k = 0; k < 45; k++) msg.push_back(64'hD0D0_0000_0000_0000 | 64'(k));
      run_msg(24, 0, 0, 0, 0, 3);

      // restart during PERM, then a short message
      msg.delete();
      for (int k = 0; k < 21; k++) msg.push_back(64'hE0E0_0000_0000_0000 | 64'(k));
      run_msg(10, 0, 0, 1, 0, 1);
      exp_blk_q.delete();
      exp_dout_q.delete();
      msg.delete();
      msg.push_back(64'hF0F0_0000_0000_0000);
      msg.push_back(64'hF0F0_0000_0000_0001);
      run_msg(3, 0, 0, 0, 0, 1);
      chk("t5_lane0", last_ps_rate[63:0], 64'hF0F0_0000_0000_0000);
      chk("t5_lane2", last_ps_rate[191:128], 64'h1F);
      chk("t5_lane3", last_ps_rate[255:192], 64'h0);

      // asynchronous reset in the middle of SQUEEZE
      msg.delete();
      for (int k = 0; k < 5; k++) msg.push_back(64'hA0A0_0000_0000_0000 | 64'(k));
      run_msg(3, 0, 0, 0, 1, 1);
      chk("pre_rst_dv", 64'(dout_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dout_valid", 64'(dout_valid), 64'd0);
      chk("arst_ready", 64'(ready), 64'd0);
      chk("arst_buffer_full", 64'(buffer_full), 64'd1);
      exp_blk_q.delete();
      exp_dout_q.delete();
      start      = 1'b1;
      last_block = 1'b0;
      din_valid  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_rate_out", 64'(|rate_out), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
